// File: rtl/seven_segment_field_pkg.sv
// Shared segment type and glyph ROM for the seven-segment field renderer.
package seg_pkg;

  // One bit per segment: bit 0 = a, bit 1 = b, ... bit 6 = g.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = '0;

  // Glyph ROM: code -> lit segments; codes 10..15 only render when hex_en is set.
  function automatic seg_t glyph_segs(input logic [3:0] code, input logic hex_en);
    seg_t s;
    case (code)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = hex_en ? 7'b1110111 : SEG_BLANK;
      4'hB: s = hex_en ? 7'b1111100 : SEG_BLANK;
      4'hC: s = hex_en ? 7'b0111001 : SEG_BLANK;
      4'hD: s = hex_en ? 7'b1011110 : SEG_BLANK;
      4'hE: s = hex_en ? 7'b1111001 : SEG_BLANK;
      default: s = hex_en ? 7'b1110001 : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment_field_glyph_hit.sv
// Combinational test of a glyph-local offset against the lit segments of a code.
module seg_glyph_hit
  import seg_pkg::*;
#(
  parameter int SEG_T  = 20,
  parameter int DIG_W  = 80,
  parameter int DIG_H  = 140,
  parameter bit HEX_EN = 1'b0
) (
  input  logic [10:0] ox,
  input  logic [10:0] oy,
  input  logic [3:0]  code,
  output logic        hit
);

  localparam int          M       = (DIG_H - SEG_T) / 2;
  localparam logic [10:0] THICK   = 11'(SEG_T);
  localparam logic [10:0] R_EDGE  = 11'(DIG_W - SEG_T);
  localparam logic [10:0] B_EDGE  = 11'(DIG_H - SEG_T);
  localparam logic [10:0] MID     = 11'(M);
  localparam logic [10:0] MID_END = 11'(M + SEG_T);

  seg_t region;
  seg_t segs;

  // Which segment regions contain the offset, masked by the glyph pattern.
  always_comb begin
    region    = SEG_BLANK;
    region[0] = oy < THICK;
    region[1] = (ox >= R_EDGE) && (oy < MID_END);
    region[2] = (ox >= R_EDGE) && (oy >= MID);
    region[3] = oy >= B_EDGE;
    region[4] = (ox < THICK) && (oy >= MID);
    region[5] = (ox < THICK) && (oy < MID_END);
    region[6] = (oy >= MID) && (oy < MID_END);
    segs      = glyph_segs(code, HEX_EN);
    hit       = |(segs & region);
  end

endmodule

// File: rtl/seven_segment_field.sv
// Two-stage raster renderer for a row of scalable seven-segment digits.
module seven_segment_field
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_T        = 20,
  parameter int DIG_W        = 80,
  parameter int DIG_H        = 140,
  parameter int GAP          = 20,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int HEX_EN       = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              frame_start,
  input  logic [9:0]                                        sx,
  input  logic [9:0]                                        sy,
  input  logic                                              upd_valid,
  output logic                                              upd_ready,
  input  logic [4*NUM_DIGITS-1:0]                           upd_digits,
  input  logic [NUM_DIGITS-1:0]                             upd_blink,
  input  logic                                              lz_en,
  output logic                                              pixel_on,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] pixel_digit
);

  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PITCH = DIG_W + GAP;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] CNT_LAST = BW'(BLINK_FRAMES - 1);

  logic [4*NUM_DIGITS-1:0] active_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   active_blink, pend_blink;
  logic                    pend_full;
  logic [BW-1:0]           frame_cnt;
  logic                    blink_on;

  assign upd_ready = ~pend_full;

  // Double buffer: accept into the pending slot, promote only at frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_digits <= '0;
      active_blink  <= '0;
      pend_digits   <= '0;
      pend_blink    <= '0;
      pend_full     <= 1'b0;
    end else if (frame_start && pend_full) begin
      active_digits <= pend_digits;
      active_blink  <= pend_blink;
      pend_full     <= 1'b0;
    end else if (upd_valid && !pend_full) begin
      pend_digits <= upd_digits;
      pend_blink  <= upd_blink;
      pend_full   <= 1'b1;
    end
  end

  // Frame counter drives the blink half-period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 1: locate the pixel within the row ----------------
  logic signed [10:0] rx, ry;
  logic               in_c;
  logic [DW-1:0]      idx_c;
  logic [10:0]        ox_c;

  assign rx = 11'({1'b0, sx}) - 11'(X0);
  assign ry = 11'({1'b0, sy}) - 11'(Y0);

  // Constant comparator chain over the digit cells; gaps fall through as misses.
  always_comb begin
    in_c  = 1'b0;
    idx_c = '0;
    ox_c  = '0;
    if (int'(ry) >= 0 && int'(ry) < DIG_H) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (int'(rx) >= int'(i) * PITCH && int'(rx) < int'(i) * PITCH + DIG_W) begin
          in_c  = 1'b1;
          idx_c = DW'(i);
          ox_c  = 11'(int'(rx) - int'(i) * PITCH);
        end
      end
    end
  end

  logic          s1_in;
  logic [DW-1:0] s1_idx;
  logic [10:0]   s1_ox, s1_oy;

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_in  <= 1'b0;
      s1_idx <= '0;
      s1_ox  <= '0;
      s1_oy  <= '0;
    end else begin
      s1_in  <= in_c;
      s1_idx <= idx_c;
      s1_ox  <= ox_c;
      s1_oy  <= ry;
    end
  end

  // ---------------- stage 2: segment lookup and blanking ----------------
  logic [NUM_DIGITS-1:0] lz_mask;

  // Leading-zero mask scanned from the most significant digit; last digit always shows.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    lz_mask = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (active_digits[4*(NUM_DIGITS-1-i) +: 4] != 4'h0) seen_nz = 1'b1;
      lz_mask[i] = lz_en && !seen_nz && (int'(i) != NUM_DIGITS - 1);
    end
  end

  logic [3:0] cur_code;
  logic       cur_blank;
  logic       seg_hit;

  // Select the owning digit's code and blanking state.
  always_comb begin
    cur_code  = 4'h0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (s1_idx == DW'(i)) begin
        cur_code  = active_digits[4*(NUM_DIGITS-1-i) +: 4];
        cur_blank = lz_mask[i] || (!blink_on && active_blink[i]);
      end
    end
  end

  seg_glyph_hit #(
    .SEG_T (SEG_T),
    .DIG_W (DIG_W),
    .DIG_H (DIG_H),
    .HEX_EN(HEX_EN != 0)
  ) u_hit (
    .ox  (s1_ox),
    .oy  (s1_oy),
    .code(cur_code),
    .hit (seg_hit)
  );

  // Stage 2 register: final pixel outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_on    <= 1'b0;
      pixel_digit <= '0;
    end else begin
      pixel_on    <= s1_in && !cur_blank && seg_hit;
      pixel_digit <= s1_in ? s1_idx : '0;
    end
  end

endmodule

// File: tb/tb_seven_segment_field.sv
// Scoreboard bench: two renderers (hex on / hex off) against a geometric reference model.
module tb_seven_segment_field;

  localparam int N     = 4;
  localparam int SEG_T = 20;
  localparam int DIG_W = 80;
  localparam int DIG_H = 140;
  localparam int GAP   = 20;
  localparam int X0    = 16;
  localparam int Y0    = 8;
  localparam int BF    = 2;
  localparam int PITCH = DIG_W + GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  sx = '0, sy = '0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_digits = '0;
  logic [3:0]  upd_blink = '0;
  logic        lz_en = 1'b0;
  logic        rdy_h, rdy_d, on_h, on_d;
  logic [1:0]  dig_h, dig_d;

  always #5 clk = ~clk;

  seven_segment_field #(
    .NUM_DIGITS(N), .SEG_T(SEG_T), .DIG_W(DIG_W), .DIG_H(DIG_H), .GAP(GAP),
    .X0(X0), .Y0(Y0), .HEX_EN(1), .BLINK_FRAMES(BF)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sx(sx), .sy(sy),
    .upd_valid(upd_valid), .upd_ready(rdy_h), .upd_digits(upd_digits),
    .upd_blink(upd_blink), .lz_en(lz_en), .pixel_on(on_h), .pixel_digit(dig_h)
  );

  seven_segment_field #(
    .NUM_DIGITS(N), .SEG_T(SEG_T), .DIG_W(DIG_W), .DIG_H(DIG_H), .GAP(GAP),
    .X0(X0), .Y0(Y0), .HEX_EN(0), .BLINK_FRAMES(BF)
  ) dut_dec (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sx(sx), .sy(sy),
    .upd_valid(upd_valid), .upd_ready(rdy_d), .upd_digits(upd_digits),
    .upd_blink(upd_blink), .lz_en(lz_en), .pixel_on(on_d), .pixel_digit(dig_d)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int x;
    int y;
    bit on_hex;
    bit on_dec;
    int dig;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: what the display shows and what is waiting.
  int act[N], act_bl[N], pend[N], pend_bl[N];
  bit m_full;
  int frames;
  int prev_x, prev_y;
  bit prev_rst = 1'b1;
  bit lz_cur = 1'b0;

  string glyph_str[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want,
                       input int x, input int y);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at (%0d,%0d): got %0d, expected %0d", name, x, y, got, want);
    end
  endtask

  function automatic bit in_region(input byte s, input int ox, input int oy);
    int m = (DIG_H - SEG_T) / 2;
    case (s)
      "a": return oy < SEG_T;
      "b": return ox >= DIG_W - SEG_T && oy < m + SEG_T;
      "c": return ox >= DIG_W - SEG_T && oy >= m;
      "d": return oy >= DIG_H - SEG_T;
      "e": return ox < SEG_T && oy >= m;
      "f": return ox < SEG_T && oy < m + SEG_T;
      "g": return oy >= m && oy < m + SEG_T;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int cell_of(input int x, input int y);
    int rx = x - X0;
    int ry = y - Y0;
    if (rx < 0 || ry < 0 || ry >= DIG_H) return -1;
    if (rx / PITCH >= N || rx % PITCH >= DIG_W) return -1;
    return rx / PITCH;
  endfunction

  function automatic bit model_on(input int x, input int y, input bit hex, input bit lz);
    int i = cell_of(x, y);
    string g;
    bit lead;
    if (i < 0) return 1'b0;
    if (act_bl[i] != 0 && (frames / BF) % 2 == 1) return 1'b0;
    if (lz && i != N - 1) begin
      lead = 1'b1;
      for (int k = 0; k <= i; k++) if (act[k] != 0) lead = 1'b0;
      if (lead) return 1'b0;
    end
    if (act[i] > 9 && !hex) return 1'b0;
    g = glyph_str[act[i]];
    for (int k = 0; k < g.len(); k++)
      if (in_region(g.getc(k), (x - X0) % PITCH, y - Y0)) return 1'b1;
    return 1'b0;
  endfunction

  // One pixel clock of stimulus; also predicts the output for last cycle's pixel.
  task automatic drive(input int x, input int y, input bit fs, input bit uv,
                       input logic [15:0] dg, input logic [3:0] bl, input bit rs_n);
    exp_t e;
    int c;
    @(negedge clk);
    check("upd_ready_hex", rdy_h, !m_full, x, y);
    check("upd_ready_dec", rdy_d, !m_full, x, y);
    sx = 10'(x); sy = 10'(y);
    frame_start = fs; upd_valid = uv; upd_digits = dg; upd_blink = bl;
    lz_en = lz_cur; rst_n = rs_n;
    e.x = prev_x; e.y = prev_y;
    if (!rs_n || prev_rst) begin
      e.on_hex = 1'b0; e.on_dec = 1'b0; e.dig = 0;
    end else begin
      c = cell_of(prev_x, prev_y);
      e.on_hex = model_on(prev_x, prev_y, 1'b1, lz_cur);
      e.on_dec = model_on(prev_x, prev_y, 1'b0, lz_cur);
      e.dig = (c < 0) ? 0 : c;
    end
    exp_q.push_back(e);
    if (!rs_n) begin
      for (int k = 0; k < N; k++) begin act[k] = 0; act_bl[k] = 0; end
      m_full = 1'b0;
      frames = 0;
    end else begin
      if (fs && m_full) begin
        for (int k = 0; k < N; k++) begin act[k] = pend[k]; act_bl[k] = pend_bl[k]; end
        m_full = 1'b0;
      end else if (uv && !m_full) begin
        for (int k = 0; k < N; k++) begin
          pend[k] = int'(dg[4*(N-1-k) +: 4]);
          pend_bl[k] = int'(bl[k]);
        end
        m_full = 1'b1;
      end
      if (fs) frames++;
    end
    prev_x = x; prev_y = y; prev_rst = !rs_n;
  endtask

  task automatic px(input int x, input int y);
    drive(x, y, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic rand_px(input int n);
    for (int k = 0; k < n; k++)
      px($urandom_range(0, X0 + N * PITCH + 20), $urandom_range(0, Y0 + DIG_H + 20));
  endtask

  task automatic load(input logic [15:0] dg, input logic [3:0] bl);
    drive($urandom_range(0, 500), $urandom_range(0, 200), 1'b0, 1'b1, dg, bl, 1'b1);
  endtask

  task automatic fstart();
    drive(0, 0, 1'b1, 1'b0, '0, '0, 1'b1);
  endtask

  // Monitor: every output slot has one prediction queued ahead of it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel_on_hex", on_h, e.on_hex, e.x, e.y);
        check("pixel_on_dec", on_d, e.on_dec, e.x, e.y);
        check("pixel_digit_hex", dig_h, e.dig, e.x, e.y);
        check("pixel_digit_dec", dig_d, e.dig, e.x, e.y);
      end
    end
  end

  initial begin
    logic [15:0] dg;
    for (int k = 0; k < N; k++) begin act[k] = 0; act_bl[k] = 0; pend[k] = 0; pend_bl[k] = 0; end
    m_full = 1'b0;
    frames = 0;
    repeat (2) @(posedge clk);
    repeat (3) drive(0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // All eights: lit stroke, hollow centre, gap column.
    load(16'h8888, 4'h0);
    fstart();
    px(X0 + 10, Y0 + 10);
    px(X0 + 40, Y0 + 40);
    px(X0 + 85, Y0 + 10);
    rand_px(20);

    // Mid-frame load stays pending; a second offer is refused.
    load(16'h1234, 4'h0);
    rand_px(10);
    load(16'h5678, 4'hF);
    px(X0 + 40, Y0 + 70);
    rand_px(10);
    fstart();
    px(X0 + 40, Y0 + 70);
    rand_px(30);

    // Leading-zero blanking.
    lz_cur = 1'b1;
    load(16'h0007, 4'h0);
    fstart();
    px(X0 + 10, Y0 + 10);
    px(X0 + 3 * PITCH + 10, Y0 + 10);
    rand_px(60);
    load(16'h0000, 4'h0);
    fstart();
    px(X0 + 3 * PITCH + 10, Y0 + 10);
    px(X0 + 2 * PITCH + 10, Y0 + 10);
    rand_px(60);
    lz_cur = 1'b0;

    // Blink on digit 1 only.
    load(16'h8888, 4'b0010);
    for (int f = 0; f < 8; f++) begin
      fstart();
      px(X0 + PITCH + 10, Y0 + 10);
      px(X0 + 2 * PITCH + 10, Y0 + 10);
      rand_px(20);
    end
    drive(0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    load(16'h8888, 4'b0010);
    fstart();
    px(X0 + PITCH + 10, Y0 + 10);
    rand_px(10);

    // Hex glyph A: d dark, a lit; dark on the decimal-only instance.
    load(16'hAAAA, 4'h0);
    fstart();
    px(X0 + 40, Y0 + DIG_H - 5);
    px(X0 + 40, Y0 + 5);
    px(X0 + 40, Y0 + 70);
    rand_px(30);

    // Digit index in the third cell.
    px(X0 + 2 * PITCH + 5, Y0 + 50);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++)
        dg[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) lz_cur = ~lz_cur;
      drive($urandom_range(0, X0 + N * PITCH + 20), $urandom_range(0, Y0 + DIG_H + 20),
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, dg, 4'($urandom_range(0, 15)),
            $urandom_range(0, 1499) != 0);
    end

    repeat (3) px(0, 0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
